regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_reader_pkg.sv | 20 ++
 rtl/regfile_dump_reader.sv | 152 +++++++++++++++
 tb/tb_regfile_dump_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader_pkg
//   Shared CPU constants plus the dump reader FSM encoding.
//   REG_ADDR_W / REG_DATA_W are the same widths the regFile uses, so the reader
//   and the register file agree on the geometry of the read port.
// -----------------------------------------------------------------------------
package regfile_dump_reader_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   // Dump reader FSM encoding, kept as plain 2-bit constants so the states
   // also show up as readable numbers in older tools and waveform viewers.
   typedef logic [1:0] dump_state_t;

   localparam dump_state_t DUMP_IDLE = 2'd0;
   localparam dump_state_t DUMP_READ = 2'd1;
   localparam dump_state_t DUMP_HOLD = 2'd2;

endpackage

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//   Debug read-out engine for the register file. A start pulse sweeps the
//   regFile read port from FIRST_ADDR to LAST_ADDR and emits every register as
//   an (address, data) word on a valid/ready stream, followed by a done pulse.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | rd_addr parked at FIRST_ADDR, waiting for start
//   READ  | rd_addr stable, rd_data captured into the output slice on the edge
//   HOLD  | word presented on the stream, waiting for the handshake
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   reset_i      synchronous, active-high reset
//   start_i      one-cycle sweep request (ignored while busy or on done)
//   abort_i      cancels a sweep in progress, no done pulse
//   rd_addr_o    regFile read address (RsAddr)
//   rd_data_i    regFile read data, combinational from rd_addr_o
//   out_valid_o  stream word valid
//   out_ready_i  stream sink ready
//   out_addr_o   address of the word on the stream
//   out_data_o   captured register value
//   busy_o       sweep in progress
//   done_o       one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int ADDR_W     = REG_ADDR_W,
   parameter int DATA_W     = REG_DATA_W,
   parameter int FIRST_ADDR = 1,
   parameter int LAST_ADDR  = 31
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

   if ((FIRST_ADDR > LAST_ADDR) || (FIRST_ADDR < 0) || (LAST_ADDR >= (1 << ADDR_W))) begin : g_bad_range
      $error("regfile_dump_reader: need 0 <= FIRST_ADDR <= LAST_ADDR < 2**ADDR_W");
   end

   dump_state_t       state_q,     state_d;
   logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              done_q,      done_d;

   logic              accept;
   logic              at_last;

   assign accept  = out_valid_q && out_ready_i;
   assign at_last = (rd_addr_q == LAST);

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;

      case (state_q)
         DUMP_IDLE: begin
            rd_addr_d = FIRST;
            // done_q high means the previous sweep is closing this cycle;
            // a start here is dropped so every sweep begins from a clean IDLE.
            if (start_i && !done_q) begin
               state_d = DUMP_READ;
            end
         end

         DUMP_READ: begin
            out_data_d  = rd_data_i;
            out_addr_d  = rd_addr_q;
            out_valid_d = 1'b1;
            state_d     = DUMP_HOLD;
         end

         DUMP_HOLD: begin
            if (accept) begin
               out_valid_d = 1'b0;
               if (at_last) begin
                  // Equality compare terminates the sweep, so the address
                  // never increments past LAST and cannot wrap.
                  done_d    = 1'b1;
                  rd_addr_d = FIRST;
                  state_d   = DUMP_IDLE;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
                  state_d   = DUMP_READ;
               end
            end
         end

         default: begin
            state_d     = DUMP_IDLE;
            rd_addr_d   = FIRST;
            out_valid_d = 1'b0;
         end
      endcase

      // Abort wins over everything, including a final handshake: that word
      // is considered delivered, but the sweep ends without done.
      if (abort_i && (state_q != DUMP_IDLE)) begin
         state_d     = DUMP_IDLE;
         rd_addr_d   = FIRST;
         out_valid_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= DUMP_IDLE;
         rd_addr_q   <= FIRST;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
      end
   end

   assign rd_addr_o   = rd_addr_q;
   assign out_valid_o = out_valid_q;
   assign out_addr_o  = out_addr_q;
   assign out_data_o  = out_data_q;
   assign busy_o      = (state_q != DUMP_IDLE);
   assign done_o      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
//   Bench for regfile_dump_reader. A register-file array sits beside the DUT;
//   a stream-level model predicts busy/valid/done every cycle and scores each
//   accepted word against a snapshot of the registers taken at sweep start.
//   A second instance covers the single-word FIRST_ADDR == LAST_ADDR case.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int FIRST = 1;
   localparam int LAST  = 31;

   logic          clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic          reset_i, start_i, abort_i, out_ready_i, start2_i;
   logic [AW-1:0] rd_addr_o, out_addr_o, rd_addr2, out_addr2;
   logic [DW-1:0] rd_data_i, out_data_o, rd_data2, out_data2;
   logic          out_valid_o, busy_o, done_o, out_valid2, busy2, done2;

   logic [DW-1:0] regs [0:31];
   logic          tb_init, we;
   logic [4:0]    waddr;
   logic [31:0]   wdata;

   always @(posedge clk_i) begin
      if (tb_init) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'h55aaaa55 ^ 32'(i);
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rd_data_i = regs[rd_addr_o];
   assign rd_data2  = regs[rd_addr2];

   regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .FIRST_ADDR(FIRST), .LAST_ADDR(LAST)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .rd_addr_o   (rd_addr_o),
      .rd_data_i   (rd_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_addr_o  (out_addr_o),
      .out_data_o  (out_data_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .FIRST_ADDR(4), .LAST_ADDR(4)) dut_one (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .start_i     (start2_i),
      .abort_i     (abort_i),
      .rd_addr_o   (rd_addr2),
      .rd_data_i   (rd_data2),
      .out_valid_o (out_valid2),
      .out_ready_i (out_ready_i),
      .out_addr_o  (out_addr2),
      .out_data_o  (out_data2),
      .busy_o      (busy2),
      .done_o      (done2)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- stream-level model ----------------
   bit            model_on = 1'b0;
   logic          p_valid = 1'b0, p_ready = 1'b0, p_busy = 1'b0;
   logic          p_start = 1'b0, p_abort = 1'b0, p_reset = 1'b1;
   logic [AW-1:0] p_addr = '0;
   logic [DW-1:0] p_data = '0;
   logic          m_busy = 1'b0, m_done = 1'b0;
   logic          e_busy, e_valid, e_done;
   logic [DW-1:0] snap [0:31];
   int            exp_addr = FIRST;
   int            sweep_words = 0;
   int            total_dones = 0;
   int            cyc = 0;
   int            first_valid_cyc = 0;
   int            done_cyc = 0;
   logic [DW-1:0] w_first = '0, w_last = '0, w7 = '0;

   always @(negedge clk_i) begin
      cyc++;
      if (model_on) begin
         e_busy  = p_reset ? 1'b0 :
                   p_busy  ? !(p_abort || (p_valid && p_ready && p_addr == AW'(LAST))) :
                             (p_start && !m_done);
         e_valid = (p_reset || (p_busy && p_abort)) ? 1'b0 :
                   p_valid ? !p_ready : p_busy;
         e_done  = !p_reset && p_busy && !p_abort && p_valid && p_ready && (p_addr == AW'(LAST));

         check("busy", busy_o, e_busy);
         check("out_valid", out_valid_o, e_valid);
         check("done", done_o, e_done);
         if (e_done) begin
            total_dones++;
            done_cyc = cyc;
         end
         if (p_valid && !p_ready && !p_reset && !p_abort) begin
            check("hold_addr_stable", out_addr_o, p_addr);
            check("hold_data_stable", out_data_o, p_data);
         end
         if (!e_busy) check("idle_rd_addr", rd_addr_o, FIRST);
         if (p_reset) begin
            check("reset_out_addr", out_addr_o, 0);
            check("reset_out_data", out_data_o, 0);
         end
         if (e_valid && !p_valid && exp_addr == FIRST) first_valid_cyc = cyc;

         m_busy = e_busy;
         m_done = e_done;

         if (e_valid && out_ready_i && !reset_i) begin
            check("word_addr", out_addr_o, exp_addr);
            check("word_data", out_data_o, snap[out_addr_o]);
            if (out_addr_o == AW'(1))  w_first = out_data_o;
            if (out_addr_o == AW'(31)) w_last  = out_data_o;
            if (out_addr_o == AW'(7))  w7      = out_data_o;
            exp_addr++;
            sweep_words++;
         end

         if (!m_busy && start_i && !m_done && !reset_i) begin
            for (int i = 0; i < 32; i++) snap[i] = regs[i];
            exp_addr    = FIRST;
            sweep_words = 0;
         end

         p_valid = e_valid;
         p_busy  = e_busy;
      end else begin
         p_valid = 1'b0;
         p_busy  = 1'b0;
      end
      p_addr  = out_addr_o;
      p_data  = out_data_o;
      p_ready = out_ready_i;
      p_start = start_i;
      p_abort = abort_i;
      p_reset = reset_i;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic wait_done(input int lim, input string nm);
      int n  = 0;
      int d0 = total_dones;
      while (total_dones == d0 && n < lim) begin
         tick();
         n++;
      end
      if (total_dones == d0) check({nm, "_timeout"}, 0, 1);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, n, w4;
      bit wrote;
      reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; out_ready_i = 1'b1;
      start2_i = 1'b0; we = 1'b0; waddr = '0; wdata = '0; tb_init = 1'b1;
      tick(); tick();
      model_on = 1'b1;
      tick();
      check("rst_rd_addr", rd_addr_o, 1);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_out_addr", out_addr_o, 0);
      check("rst_out_data", out_data_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      tb_init = 1'b0;
      reset_i = 1'b0;
      tick();

      // 1: full sweep, ready held high
      d0 = total_dones;
      pulse_start();
      wait_done(200, "t1");
      repeat (4) tick();
      check("t1_words", sweep_words, 31);
      check("t1_dones", total_dones - d0, 1);
      check("t1_first_data", w_first, 32'h55aaaa54);
      check("t1_last_data", w_last, 32'h55aaaa4a);
      check("t1_done_latency", done_cyc - first_valid_cyc, 61);
      check("t1_busy_after", busy_o, 0);

      // 2: random backpressure
      d0 = total_dones;
      pulse_start();
      n = 0;
      while (total_dones == d0 && n < 600) begin
         out_ready_i = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      if (total_dones == d0) check("t2_timeout", 0, 1);
      out_ready_i = 1'b1;
      repeat (3) tick();
      check("t2_words", sweep_words, 31);
      check("t2_dones", total_dones - d0, 1);

      // 3: abort after the fifth accepted word
      d0 = total_dones;
      pulse_start();
      n = 0;
      while (sweep_words < 5 && n < 100) begin
         tick();
         n++;
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("t3_valid", out_valid_o, 0);
      check("t3_busy", busy_o, 0);
      check("t3_rd_addr", rd_addr_o, 1);
      check("t3_words", sweep_words, 5);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();
      check("t3_idle_abort_busy", busy_o, 0);
      check("t3_no_done", total_dones - d0, 0);
      pulse_start();
      wait_done(200, "t3_restart");
      tick();
      check("t3_restart_words", sweep_words, 31);
      check("t3_restart_dones", total_dones - d0, 1);

      // 4: start spam during a sweep and on the done cycle
      d0 = total_dones;
      pulse_start();
      n = 0;
      while (!done_o && n < 300) begin
         start_i = ((n % 7) == 3);
         tick();
         n++;
      end
      if (!done_o) check("t4_timeout", 0, 1);
      w4 = sweep_words;
      start_i = 1'b1;
      tick();
      check("t4_start_on_done_busy", busy_o, 0);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("t4_restart_busy", busy_o, 1);
      check("t4_first_words", w4, 31);
      check("t4_first_dones", total_dones - d0, 1);
      wait_done(200, "t4_second");
      tick();
      check("t4_second_words", sweep_words, 31);
      check("t4_total_dones", total_dones - d0, 2);

      // 5: write to r7 on the edge that ends its READ cycle
      pulse_start();
      n = 0;
      wrote = 1'b0;
      d0 = total_dones;
      while (total_dones == d0 && n < 200) begin
         if (busy_o && !out_valid_o && rd_addr_o == AW'(7) && !wrote) begin
            we = 1'b1; waddr = 5'd7; wdata = 32'hdeadbeef; wrote = 1'b1;
         end else begin
            we = 1'b0;
         end
         tick();
         n++;
      end
      we = 1'b0;
      if (total_dones == d0) check("t5_timeout", 0, 1);
      check("t5_old_value", w7, 32'h55aaaa52);
      tick();
      pulse_start();
      wait_done(200, "t5_second");
      check("t5_new_value", w7, 32'hdeadbeef);
      tick();

      // 6: reset while holding addr 12
      d0 = total_dones;
      pulse_start();
      n = 0;
      while (!(busy_o && !out_valid_o && rd_addr_o == AW'(12)) && n < 100) begin
         tick();
         n++;
      end
      out_ready_i = 1'b0;
      tick();
      check("t6_hold_addr", out_addr_o, 12);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("t6_valid", out_valid_o, 0);
      check("t6_out_addr", out_addr_o, 0);
      check("t6_out_data", out_data_o, 0);
      check("t6_busy", busy_o, 0);
      check("t6_rd_addr", rd_addr_o, 1);
      check("t6_done", done_o, 0);
      out_ready_i = 1'b1;
      tick();
      check("t6_no_done", total_dones - d0, 0);

      // 6b: single-word sweep with FIRST_ADDR == LAST_ADDR == 4
      start2_i = 1'b1;
      tick();
      start2_i = 1'b0;
      check("one_read_valid", out_valid2, 0);
      check("one_read_busy", busy2, 1);
      tick();
      check("one_valid", out_valid2, 1);
      check("one_addr", out_addr2, 4);
      check("one_data", out_data2, 32'h55aaaa51);
      tick();
      check("one_done", done2, 1);
      check("one_busy_after", busy2, 0);
      check("one_valid_after", out_valid2, 0);
      tick();
      check("one_done_pulse", done2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
